pipelined_cpa: RTL
==================

Name: pipelined_cpa

Overview:
- Parametrised, pipelined carry-propagate adder for the log-conversion datapath; successor to the fixed 13-bit ripple adder.
- Operands are split into SEG_WIDTH-bit segments, with one ripple segment per pipeline stage and the carry registered between stages.
- Adds carry-in, carry-out and a valid/ready handshake with backpressure, so it sits directly between pipelined producer/consumer blocks.

Parameters:
- WIDTH, 13, operand and sum width in bits (>=2).
- SEG_WIDTH, 4, bits resolved per stage (1..WIDTH); last segment may be narrower.
- NSTAGES, derived = ceil(WIDTH/SEG_WIDTH), pipeline depth; not overridable.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block accepts operands this cycle.
- a  in  WIDTH  operand A (unsigned).
- b  in  WIDTH  operand B (unsigned).
- cin  in  1  carry-in.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- s  out  WIDTH  sum, (a+b+cin) mod 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1.

Behaviour:
- Global-enable pipeline: adv = !out_valid || out_ready; in_ready = adv (combinational from out_valid/out_ready only).
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- When adv=1, every stage register loads from its predecessor; stage 0 loads {a, b, cin, in_valid}. When adv=0, all stage registers hold, including s, cout and out_valid.
- Stage k (0-based) adds segment k of the skewed A/B with the carry registered from stage k-1 (stage 0 uses cin). Stage k registers:
  - result segment k;
  - carry into stage k+1;
  - segments 0..k-1 already computed;
  - raw operand segments k+1..NSTAGES-1.
- Registers no longer needed are dropped, so s is assembled staircase-style.
- Latency: exactly NSTAGES cycles from input transfer to out_valid with no stall; each stall cycle adds one. Throughput is 1 result/cycle while out_ready=1.
- Results leave in input order; no bubbles are inserted. A bubble (in_valid=0 while adv=1) propagates as valid=0.
- NSTAGES=1 degenerates to a single registered ripple adder.
- Carry chain wrap: 2^WIDTH-1 + 0 + cin=1 gives s=0, cout=1.
- Reset (async assert, any time including mid-stream): all valid bits = 0, out_valid=0, s=0, cout=0, and in-flight data is discarded. in_ready=1 right after reset.
- Reset deassertion is synchronous to clk at system level; no other requirement.
- Data registers with valid=0 are don't-care except s/cout, which hold their last value.

Optional Feature:
- Macro: PIPELINED_CPA_SUB_EN.
- Defined: extra input port sub (1 bit) is sampled with the operands. When sub=1, stage 0 uses ~b and carry-in 1 (cin ignored), so s = a-b mod 2^WIDTH and cout=1 means no borrow (a>=b unsigned). sub is not pipelined, since it affects only the stage-0 inputs.
- Not defined: no sub port; addition only, as described above.

Decomposition:
- Package cpa_pkg:
  - function cpa_nstages(width, seg) computing the ceiling division;
  - function seg_lo(k, seg) / seg_w(k, width, seg) giving the bit offset and width of segment k;
  - default constants CPA_WIDTH=13 and CPA_SEG_WIDTH=4.
- One sub-module, cpa_segment: a combinational ripple of a parametrised width with cin/cout, built from the existing full_adder cell. It is instantiated once per stage in a generate loop.

Test Plan (WIDTH=13, SEG_WIDTH=4, NSTAGES=4 unless stated):
- a=13'h0123, b=13'h0456, cin=0, out_ready=1 held -> out_valid on the 4th rising edge after acceptance, s=13'h0579, cout=0.
- a=13'h1FFF, b=13'h0000, cin=1 -> s=13'h0000, cout=1; confirms the carry ripples across all four stage registers.
- Back-to-back stream of 20 random operand pairs with out_ready=1 -> 20 results in order, one per cycle, matching the reference model (a+b+cin).
- Stream of 6 pairs; drop out_ready to 0 for 3 cycles once out_valid=1 -> in_ready=0 during the stall, s/cout/out_valid held constant, no loss or duplication, order preserved.
- Assert rst_n=0 for one cycle with 3 transactions in flight -> out_valid=0 and s=0 immediately (async); no stale result appears afterwards. A new pair a=13'h0001, b=13'h0001 then gives s=13'h0002.
- PIPELINED_CPA_SUB_EN defined: a=13'h0005, b=13'h0007, sub=1 -> s=13'h1FFE, cout=0; a=13'h0007, b=13'h0005, sub=1 -> s=13'h0002, cout=1. Repeat the first scenario with WIDTH=16, SEG_WIDTH=16 (NSTAGES=1) to check a latency of 1.

Source files
------------

// File: rtl/cpa_pkg.sv
// Shared sizing helpers for the pipelined carry-propagate adder.
// Segment k covers bits [seg_lo(k) +: seg_w(k)]; the last segment may be narrower.
package cpa_pkg;

    localparam int CPA_WIDTH     = 13;
    localparam int CPA_SEG_WIDTH = 4;

    function automatic int cpa_nstages(input int width, input int seg);
        return (width + seg - 1) / seg;
    endfunction

    function automatic int seg_lo(input int k, input int seg);
        return k * seg;
    endfunction

    function automatic int seg_w(input int k, input int width, input int seg);
        int rem;
        rem = width - k * seg;
        return (rem < seg) ? rem : seg;
    endfunction

endpackage

// File: rtl/cpa_segment.sv
// Combinational W-bit ripple adder built from full_adder cells.
// Ports: a_i/b_i operands, c_i carry-in; s_o sum, c_o carry-out.
module cpa_segment #(
    parameter int W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         c_i,
    output logic [W-1:0] s_o,
    output logic         c_o
);

    logic [W:0] c;

    assign c[0] = c_i;

    for (genvar i = 0; i < W; i++) begin : g_bit
        full_adder u_fa (
            .a_i(a_i[i]),
            .b_i(b_i[i]),
            .c_i(c[i]),
            .s_o(s_o[i]),
            .c_o(c[i+1])
        );
    end

    assign c_o = c[W];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell.
// Ports: a_i, b_i, c_i in; s_o sum, c_o carry out.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/pipelined_cpa.sv
// Pipelined carry-propagate adder: one SEG_WIDTH ripple segment per stage,
// carry registered between stages, global-enable valid/ready handshake.
// Ports: clk, rst_n (async low); in_valid/in_ready, a, b, cin upstream;
// out_valid/out_ready, s, cout downstream.
// Macro PIPELINED_CPA_SUB_EN adds input sub: s = a - b, cout = no-borrow.
module pipelined_cpa
    import cpa_pkg::*;
#(
    parameter int WIDTH     = CPA_WIDTH,
    parameter int SEG_WIDTH = CPA_SEG_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef PIPELINED_CPA_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    localparam int NSTAGES = cpa_nstages(WIDTH, SEG_WIDTH);

    logic             adv;
    logic [WIDTH-1:0] b0;
    logic             c0;

`ifdef PIPELINED_CPA_SUB_EN
    assign b0 = sub ? ~b : b;
    assign c0 = sub ? 1'b1 : cin;
`else
    assign b0 = b;
    assign c0 = cin;
`endif

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Stage data word layout (input to stage k, width 2*WIDTH-LO):
    //   [LO-1:0]          sum bits already resolved
    //   [WIDTH-1:LO]      raw A bits, kept at their natural positions
    //   [2*WIDTH-LO-1:W]  raw B bits LO..WIDTH-1
    // Each stage replaces its A segment by the sum and drops its B segment,
    // so the word shrinks by SW bits per stage and ends as exactly s.
    for (genvar k = 0; k < NSTAGES; k++) begin : g_stg
        localparam int LO = seg_lo(k, SEG_WIDTH);
        localparam int SW = seg_w(k, WIDTH, SEG_WIDTH);
        localparam int HI = LO + SW;
        localparam int IW = 2 * WIDTH - LO;
        localparam int OW = 2 * WIDTH - HI;
        localparam logic [WIDTH-1:0] ONES  = '1;
        localparam logic [WIDTH-1:0] SMASK = (ONES >> (WIDTH - SW)) << LO;

        logic [IW-1:0]    din;
        logic             cy_i;
        logic             vld_i;
        logic [SW-1:0]    seg_s;
        logic             seg_c;
        logic [WIDTH-1:0] lo_d;
        logic [IW-1:0]    hi_d;
        logic [OW-1:0]    dat_d;
        logic [OW-1:0]    dat_q;
        logic             cy_q;
        logic             vld_q;

        if (k == 0) begin : g_head
            assign din   = {b0, a};
            assign cy_i  = c0;
            assign vld_i = in_valid;
        end else begin : g_tail
            assign din   = g_stg[k-1].dat_q;
            assign cy_i  = g_stg[k-1].cy_q;
            assign vld_i = g_stg[k-1].vld_q;
        end

        cpa_segment #(
            .W(SW)
        ) u_seg (
            .a_i(din[HI-1:LO]),
            .b_i(din[WIDTH+SW-1:WIDTH]),
            .c_i(cy_i),
            .s_o(seg_s),
            .c_o(seg_c)
        );

        assign lo_d  = (din[WIDTH-1:0] & ~SMASK) | (WIDTH'(seg_s) << LO);
        assign hi_d  = (din >> (WIDTH + SW)) << WIDTH;
        assign dat_d = OW'(hi_d | IW'(lo_d));

        // Data only loads with a valid token so the last stage (s/cout)
        // keeps its value across bubbles.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dat_q <= '0;
                cy_q  <= 1'b0;
                vld_q <= 1'b0;
            end else if (adv) begin
                vld_q <= vld_i;
                if (vld_i) begin
                    dat_q <= dat_d;
                    cy_q  <= seg_c;
                end
            end
        end
    end

    assign s         = g_stg[NSTAGES-1].dat_q;
    assign cout      = g_stg[NSTAGES-1].cy_q;
    assign out_valid = g_stg[NSTAGES-1].vld_q;

endmodule
